adder_arbiter: RTL and testbench

- Shares one WIDTH-bit adder between NUM_REQ requesters, such as AES round-key address generation, the PC-relative path and the load/store address path.
- Round-robin grant with per-requester valid/ready handshake.
- Single registered result stage; each response is tagged with the winning requester ID.
- Sits between the requesting units and the existing combinational adder module, which it instantiates once.

---
 rtl/adder_arbiter_pkg.sv | 15 +
 rtl/adder.sv | 12 +
 rtl/adder_arbiter_rr.sv | 36 +++
 rtl/adder_arbiter.sv | 80 ++++++++
 tb/tb_adder_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared constants and helpers for the adder arbiter and its round-robin selector.
package adder_arbiter_pkg;

  localparam int MAX_REQ = 16;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Next round-robin index; stays inside 0..n-1 even when n is not a power of two.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/adder.sv
// Existing combinational adder shared by the address-generation paths.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/adder_arbiter_rr.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  always_comb begin
    grant   = '0;
    winner  = '0;
    any_req = 1'b0;
    // First pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req[i] && (ID_W'(i) >= ptr)) begin
        any_req  = 1'b1;
        winner   = ID_W'(i);
        grant[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req[i]) begin
        any_req  = 1'b1;
        winner   = ID_W'(i);
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder between NUM_REQ requesters with round-robin grant and a
// single registered, ID-tagged result stage.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  localparam int ID_W   = id_width(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_operand_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_operand_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_result,
  output logic [ID_W-1:0]          resp_id
);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic               any_req;
  logic               accept;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   sum;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .grant   (grant),
    .winner  (winner),
    .any_req (any_req)
  );

  // AND-OR operand mux driven by the one-hot grant.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        op_a = op_a | req_operand_a[i*WIDTH +: WIDTH];
        op_b = op_b | req_operand_b[i*WIDTH +: WIDTH];
      end
    end
  end

  adder #(.WIDTH(WIDTH)) u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  assign accept    = ~resp_valid | resp_ready;
  assign req_ready = accept ? grant : '0;
  assign ptr_next  = ID_W'(rr_next(int'(winner), NUM_REQ));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_id     <= '0;
    end else if (accept) begin
      if (any_req) begin
        resp_valid  <= 1'b1;
        resp_result <= sum;
        resp_id     <= winner;
        ptr         <= ptr_next;
      end else begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: queue-based reference model plus a
// NUM_REQ=3 instance for pointer wrap.
module tb_adder_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_operand_a;
  logic [N*W-1:0] req_operand_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_result;
  logic [1:0]     resp_id;

  logic [2:0]     req_valid3 = '0;
  logic [2:0]     req_ready3;
  logic [3*W-1:0] req_operand_a3 = '0;
  logic [3*W-1:0] req_operand_b3 = '0;
  logic           resp_valid3;
  logic           resp_ready3 = 1'b1;
  logic [W-1:0]   resp_result3;
  logic [1:0]     resp_id3;

  always #5 clock = ~clock;

  adder_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_operand_a (req_operand_a),
    .req_operand_b (req_operand_b),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_result   (resp_result),
    .resp_id       (resp_id)
  );

  adder_arbiter #(.WIDTH(W), .NUM_REQ(3)) dut3 (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid3),
    .req_ready     (req_ready3),
    .req_operand_a (req_operand_a3),
    .req_operand_b (req_operand_b3),
    .resp_valid    (resp_valid3),
    .resp_ready    (resp_ready3),
    .resp_result   (resp_result3),
    .resp_id       (resp_id3)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         id;
    logic [W-1:0] sum;
  } exp_t;
  exp_t exp_q[$];

  // Requester-side view: pending operation per requester, held until granted.
  logic [N-1:0] pv = '0;
  logic [W-1:0] pa[N];
  logic [W-1:0] pb[N];
  logic         rr_in = 1'b1;
  int           m_ptr = 0;
  bit           m_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    req_valid  = pv;
    resp_ready = rr_in;
    for (int i = 0; i < N; i++) begin
      req_operand_a[i*W +: W] = pa[i];
      req_operand_b[i*W +: W] = pb[i];
    end
  endtask

  // One clock of the reference model; entered and left at posedge+1.
  task automatic step();
    int           w;
    bit           found;
    bit           acc;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] s;
    @(negedge clock);
    found = 1'b0;
    w     = 0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (!found && pv[idx]) begin
        found = 1'b1;
        w     = idx;
      end
    end
    acc     = !m_valid || rr_in;
    exp_rdy = '0;
    if (acc && found) exp_rdy[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clock);
    if (acc) begin
      if (found) begin
        s = pa[w] + pb[w];
        exp_q.push_back('{id: w, sum: s});
        pv[w]   = 1'b0;
        m_ptr   = (w + 1) % N;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    apply();
  endtask

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(3, 0))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: the held result must match the head of the expectation queue.
  always @(negedge clock) begin
    if (!reset) begin
      chk("resp_valid", 64'(resp_valid), 64'(exp_q.size() != 0));
      if (resp_valid && exp_q.size() != 0) begin
        chk("resp_id", 64'(resp_id), 64'(exp_q[0].id));
        chk("resp_result", 64'(resp_result), 64'(exp_q[0].sum));
        if (resp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
    apply();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Build a held result, stall, then reset in the middle of the stall.
    pv[1] = 1'b1; pa[1] = 32'd3; pb[1] = 32'd4; rr_in = 1'b0;
    apply();
    step();
    step();
    step();
    chk("held_result", 64'(resp_result), 64'd7);
    reset   = 1'b1;
    exp_q.delete();
    m_valid = 1'b0;
    m_ptr   = 0;
    pv      = '0;
    rr_in   = 1'b1;
    apply();
    #1;
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_result", 64'(resp_result), 64'd0);
    chk("rst_id", 64'(resp_id), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    pv[2] = 1'b1; pa[2] = 32'd5; pb[2] = 32'd7;
    apply();
    step();
    chk("first_result", 64'(resp_result), 64'd12);
    chk("first_id", 64'(resp_id), 64'd2);

    // Round-robin with every requester held valid.
    for (int i = 0; i < N; i++) begin
      pa[i] = W'(i);
      pb[i] = 32'd100;
    end
    pv = '1;
    apply();
    for (int c = 0; c < 8; c++) begin
      step();
      pv = '1;
      apply();
    end

    // Backpressure for three cycles, then release.
    rr_in = 1'b0;
    apply();
    repeat (3) step();
    rr_in = 1'b1;
    apply();
    step();
    pv = '0;
    apply();
    repeat (3) step();

    // Modular wrap of the sum (ptr is 0 here after the round-robin drain).
    pv[0] = 1'b1; pa[0] = 32'hFFFF_FFFF; pb[0] = 32'h0000_0001;
    apply();
    step();
    chk("wrap_ff", 64'(resp_result), 64'd0);
    pv[1] = 1'b1; pa[1] = 32'h8000_0000; pb[1] = 32'h8000_0000;
    apply();
    step();
    chk("wrap_80", 64'(resp_result), 64'd0);
    chk("wrap_valid", 64'(resp_valid), 64'd1);

    // Pointer skip: move ptr to 1, then only requesters 0 and 3.
    pv[0] = 1'b1; pa[0] = 32'd1; pb[0] = 32'd1;
    apply();
    step();
    pv[0] = 1'b1; pv[3] = 1'b1; pa[3] = 32'd30; pb[3] = 32'd3;
    apply();
    step();
    chk("skip_to_3", 64'(resp_id), 64'd3);
    step();
    chk("wrap_to_0", 64'(resp_id), 64'd0);

    // Idle drain: one request, valid for exactly one cycle, ptr left at 3.
    step();
    pv[2] = 1'b1; pa[2] = 32'd9; pb[2] = 32'd9;
    apply();
    step();
    chk("drain_valid_hi", 64'(resp_valid), 64'd1);
    step();
    chk("drain_valid_lo", 64'(resp_valid), 64'd0);
    pv[0] = 1'b1; pv[3] = 1'b1;
    apply();
    step();
    chk("drain_ptr", 64'(resp_id), 64'd3);
    step();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(1, 0) == 1) begin
          pv[i] = 1'b1;
          pa[i] = rnd();
          pb[i] = rnd();
        end
      end
      rr_in = ($urandom_range(3, 0) != 0);
      apply();
      step();
    end
    rr_in = 1'b1;
    apply();
    repeat (N + 3) step();
    pv = '0;
    apply();
    repeat (3) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // NUM_REQ=3 instance: ptr must wrap 2 -> 0.
    for (int i = 0; i < 3; i++) begin
      req_operand_a3[i*W +: W] = W'(i * 10);
      req_operand_b3[i*W +: W] = 32'd1;
    end
    req_valid3 = '1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #1;
      chk("n3_id", 64'(resp_id3), 64'(k % 3));
      chk("n3_result", 64'(resp_result3), 64'((k % 3) * 10 + 1));
    end
    req_valid3 = '0;
    @(posedge clock);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
